// File: rtl/load_arbiter.sv
// load_arbiter: round-robin arbiter with optional ownership lock that feeds
// one shared register. Grants are combinational; the load/data/id outputs
// are registered and appear one cycle after the transfer.
module load_arbiter #(
  parameter int WIDTH    = 32,
  parameter int N        = 4,
  parameter int LOCK_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N-1:0]         req_lock,
  input  logic [N*WIDTH-1:0]   req_data,
  output logic [N-1:0]         req_ready,
  output logic                 load,
  output logic [WIDTH-1:0]     d,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 locked
);

  localparam int PW = $clog2(N);

  // Reject illegal configurations at elaboration time.
  if (N < 2 || N > 8) begin : g_bad_n
    $error("load_arbiter: N must be in 2..8");
  end
  if (LOCK_MAX < 1 || LOCK_MAX > 255) begin : g_bad_lock_max
    $error("load_arbiter: LOCK_MAX must be in 1..255");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Last idle-cycle count before a silent owner loses its lock.
  localparam logic [7:0] IDLE_LIMIT = 8'(LOCK_MAX - 1);

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [PW-1:0]   owner, owner_n;
  logic [7:0]      idle_cnt, idle_cnt_n;

  logic            rr_found;
  logic [PW-1:0]   rr_win;
  logic [PW-1:0]   grant_idx;
  logic            xfer;

  // Round-robin search: first valid requester starting just after ptr.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // that no path leaves it unassigned, which would infer a latch.
    rr_found = 1'b0;
    rr_win   = '0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!rr_found && req_valid[idx]) begin
        rr_found = 1'b1;
        rr_win   = idx[PW-1:0];
      end
    end
  end

  // Next-state logic and grant generation for the IDLE/LOCKED machine.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    owner_n    = owner;
    idle_cnt_n = idle_cnt;
    req_ready  = '0;
    grant_idx  = owner;

    unique case (state)
      IDLE: begin
        if (rr_found) begin
          req_ready[rr_win] = 1'b1;
          grant_idx         = rr_win;
          ptr_n             = rr_win;
          if (req_lock[rr_win]) begin
            state_n    = LOCKED;
            owner_n    = rr_win;
            idle_cnt_n = '0;
          end
        end
      end
      LOCKED: begin
        if (req_valid[owner]) begin
          req_ready[owner] = 1'b1;
          grant_idx        = owner;
          if (req_lock[owner]) begin
            idle_cnt_n = '0;
          end else begin
            state_n = IDLE;
            ptr_n   = owner;
          end
        end else if (idle_cnt >= IDLE_LIMIT) begin
          // Owner stayed silent too long: release without granting anyone.
          state_n    = IDLE;
          ptr_n      = owner;
          idle_cnt_n = '0;
        end else if (idle_cnt != 8'hFF) begin
          idle_cnt_n = idle_cnt + 8'd1;
        end
      end
    endcase

    // No grant can be given while reset is held.
    if (rst) begin
      req_ready = '0;
    end
  end

  assign xfer   = |req_ready;
  assign locked = (state == LOCKED);

  // State register: machine state, priority pointer, lock owner, idle counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state    <= IDLE;
      ptr      <= PW'(N - 1);
      owner    <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      idle_cnt <= idle_cnt_n;
    end
  end

  // Output register: one-cycle load pulse with held data and requester index.
  always_ff @(posedge clk) begin
    if (rst) begin
      load     <= 1'b0;
      d        <= '0;
      grant_id <= '0;
    end else begin
      load <= xfer;
      if (xfer) begin
        d        <= req_data[int'(grant_idx)*WIDTH +: WIDTH];
        grant_id <= grant_idx;
      end
    end
  end

endmodule
